// File: rtl/pcie_ingress_pkg.sv
// rtl/pcie_ingress_pkg.sv - shared TLP codes, header bit positions and ingress types
//
// Purpose : constants and types shared by the PCIe ingress FSM and its
//           header decoder.
// Ports   : none (package).
package pcie_ingress_pkg;

   // DW0 bit positions
   localparam int unsigned DW0_FMT_DATA_BIT = 30;   // TLP carries payload
   localparam int unsigned DW0_FMT_4DW_BIT  = 29;   // 4DW header
   localparam int unsigned DW0_EP_BIT       = 14;   // poisoned TLP

   // fmt/type codes for completions
   localparam logic [7:0] PCIE_CPL  = 8'h0A;
   localparam logic [7:0] PCIE_CPLD = 8'h4A;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ_HDR,
      ST_WAIT_FOR_FIFO,
      ST_READ_DATA,
      ST_DRAIN,
      ST_FINISHED
   } ingress_state_e;

   typedef struct packed {
      logic [7:0]  command;
      logic [13:0] flags;
      logic [10:0] dword_count;
      logic [15:0] requester_id;
      logic [7:0]  tag;
      logic [15:0] completer_id;
      logic [2:0]  cpl_status;
      logic [11:0] byte_count;
      logic [31:0] address;
   } hdr_fields_t;

   function automatic logic is_completion(input logic [7:0] cmd);
      return (cmd == PCIE_CPL) || (cmd == PCIE_CPLD);
   endfunction

endpackage

// File: rtl/pcie_ingress_hdr_decode.sv
// rtl/pcie_ingress_hdr_decode.sv - combinational TLP header field decoder
//
// Purpose : maps four header DWORDs onto the controller-facing fields.
// Ports   : i_hdr    - header DWORDs, i_hdr[0] is DW0
//           o_fields - decoded header fields
module pcie_ingress_hdr_decode
   import pcie_ingress_pkg::*;
(
   input  logic [3:0][31:0] i_hdr,
   output hdr_fields_t      o_fields
);

   logic is_4dw;
   logic is_cpl;

   always_comb begin
      is_4dw   = i_hdr[0][DW0_FMT_4DW_BIT];
      is_cpl   = is_completion(i_hdr[0][31:24]);
      o_fields = '0;
      o_fields.command = i_hdr[0][31:24];
      o_fields.flags   = i_hdr[0][23:10];
      // a length field of 0 encodes the maximum of 1024 DWORDs
      o_fields.dword_count = (i_hdr[0][9:0] == 10'd0) ? 11'd1024 : {1'b0, i_hdr[0][9:0]};
      if (is_cpl) begin
         o_fields.completer_id = i_hdr[1][31:16];
         o_fields.cpl_status   = i_hdr[1][15:13];
         o_fields.byte_count   = i_hdr[1][11:0];
         o_fields.requester_id = i_hdr[2][31:16];
         o_fields.tag          = i_hdr[2][15:8];
         o_fields.address      = {25'h0, i_hdr[2][6:0]};
      end else begin
         o_fields.requester_id = i_hdr[1][31:16];
         o_fields.tag          = i_hdr[1][15:8];
         // the address always sits in the last header DWORD
         o_fields.address      = is_4dw ? i_hdr[3] : i_hdr[2];
      end
   end

endmodule

// File: rtl/pcie_ingress.sv
// rtl/pcie_ingress.sv - PCIe receive TLP parser feeding the incoming payload FIFO
//
// Purpose : accepts one TLP per i_enable handshake from the core's AXI-Stream
//           host-to-device port, decodes its header and writes payload
//           DWORDs into the incoming FIFO.
// Config  : PCIE_INGRESS_DROP_POISONED_EN - drain poisoned data TLPs instead
//           of writing their payload.
// Ports   : clk, rst                     - clock, synchronous active-high reset
//           i_enable / o_finished        - per-TLP controller handshake
//           o_hdr_stb, o_error           - header valid pulse, sticky packet error
//           o_command .. o_address       - decoded header fields
//           i_axi_ingress_* / o_axi_ingress_ready - TLP input stream
//           i_fifo_rdy, o_fifo_act, i_fifo_size   - FIFO claim interface
//           o_fifo_data, o_fifo_stb      - payload write port
module pcie_ingress
   import pcie_ingress_pkg::*;
#(
   parameter int unsigned MAX_PAYLOAD_DW  = 128,
   parameter int unsigned FIFO_SIZE_WIDTH = 24
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_enable,
   output logic                       o_finished,
   output logic                       o_hdr_stb,
   output logic                       o_error,
   output logic [7:0]                 o_command,
   output logic [13:0]                o_flags,
   output logic [10:0]                o_dword_count,
   output logic [15:0]                o_requester_id,
   output logic [7:0]                 o_tag,
   output logic [15:0]                o_completer_id,
   output logic [2:0]                 o_cpl_status,
   output logic [11:0]                o_byte_count,
   output logic [31:0]                o_address,
   input  logic [31:0]                i_axi_ingress_data,
   input  logic [3:0]                 i_axi_ingress_keep,
   input  logic                       i_axi_ingress_last,
   input  logic                       i_axi_ingress_valid,
   output logic                       o_axi_ingress_ready,
   input  logic                       i_fifo_rdy,
   output logic                       o_fifo_act,
   input  logic [FIFO_SIZE_WIDTH-1:0] i_fifo_size,
   output logic [31:0]                o_fifo_data,
   output logic                       o_fifo_stb
);

   ingress_state_e               state_q, state_d;
   logic [1:0]                   idx_q, idx_d;
   logic [3:0][31:0]             hdr_q, hdr_d;
   hdr_fields_t                  fields_q, fields_d;
   logic                         hdr_stb_q, hdr_stb_d;
   logic                         error_q, error_d;
   logic                         act_q, act_d;
   logic                         finished_q, finished_d;
   logic [FIFO_SIZE_WIDTH-1:0]   count_q, count_d;

   logic [3:0][31:0]             hdr_cur;
   hdr_fields_t                  dec_fields;
   logic                         beat;
   logic                         is_data;
   logic [1:0]                   hdr_last;
   logic                         poisoned;
   logic [FIFO_SIZE_WIDTH-1:0]   dword_count_ext;
   logic [FIFO_SIZE_WIDTH-1:0]   count_inc;

   assign o_axi_ingress_ready = (state_q == ST_READ_HDR) || (state_q == ST_READ_DATA) ||
                                (state_q == ST_DRAIN);
   assign beat        = i_axi_ingress_valid & o_axi_ingress_ready;
   assign o_fifo_data = i_axi_ingress_data;
   // header beats never strobe, so only payload beats reach the FIFO
   assign o_fifo_stb  = beat && (state_q == ST_READ_DATA);

   // header as it will look once the current beat is stored, so the final
   // header beat can be decoded in the same cycle it arrives
   always_comb begin
      hdr_cur         = hdr_q;
      hdr_cur[idx_q]  = i_axi_ingress_data;
   end

   assign is_data  = hdr_cur[0][DW0_FMT_DATA_BIT];
   assign hdr_last = hdr_cur[0][DW0_FMT_4DW_BIT] ? 2'd3 : 2'd2;

`ifdef PCIE_INGRESS_DROP_POISONED_EN
   assign poisoned = hdr_cur[0][DW0_EP_BIT];
`else
   assign poisoned = 1'b0;
   logic unused_ep;
   assign unused_ep = hdr_cur[0][DW0_EP_BIT];
`endif

   assign dword_count_ext = FIFO_SIZE_WIDTH'(fields_q.dword_count);
   assign count_inc       = count_q + FIFO_SIZE_WIDTH'(1);

   pcie_ingress_hdr_decode u_hdr_decode (
      .i_hdr    (hdr_cur),
      .o_fields (dec_fields)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      hdr_d      = hdr_q;
      fields_d   = fields_q;
      hdr_stb_d  = 1'b0;
      error_d    = error_q;
      act_d      = act_q;
      finished_d = finished_q;
      count_d    = count_q;

      case (state_q)
         ST_IDLE: begin
            error_d = 1'b0;
            idx_d   = 2'd0;
            if (i_enable) state_d = ST_READ_HDR;
         end
         ST_READ_HDR: begin
            if (beat) begin
               hdr_d = hdr_cur;
               idx_d = idx_q + 2'd1;
               if (idx_q == hdr_last) begin
                  hdr_stb_d = 1'b1;
                  fields_d  = dec_fields;
                  if (!is_data) begin
                     if (i_axi_ingress_last) begin
                        state_d = ST_FINISHED;
                     end else begin
                        error_d = 1'b1;
                        state_d = ST_DRAIN;
                     end
                  end else if (i_axi_ingress_last) begin
                     error_d = 1'b1;
                     state_d = ST_FINISHED;
                  end else if (dec_fields.dword_count > 11'(MAX_PAYLOAD_DW) || poisoned) begin
                     error_d = 1'b1;
                     state_d = ST_DRAIN;
                  end else begin
                     state_d = ST_WAIT_FOR_FIFO;
                  end
               end else if (i_axi_ingress_last) begin
                  // packet ended inside its own header
                  error_d = 1'b1;
                  state_d = ST_FINISHED;
               end
            end
         end
         ST_WAIT_FOR_FIFO: begin
            // claim first, then check capacity once the claim is held
            if (!act_q) begin
               if (i_fifo_rdy) begin
                  act_d   = 1'b1;
                  count_d = '0;
               end
            end else if (i_fifo_size < dword_count_ext) begin
               error_d = 1'b1;
               act_d   = 1'b0;
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_READ_DATA;
            end
         end
         ST_READ_DATA: begin
            if (beat) begin
               count_d = count_inc;
               if (count_inc == dword_count_ext) begin
                  if (i_axi_ingress_last) begin
                     state_d = ST_FINISHED;
                  end else begin
                     error_d = 1'b1;
                     state_d = ST_DRAIN;
                  end
               end else if (i_axi_ingress_last) begin
                  error_d = 1'b1;
                  state_d = ST_FINISHED;
               end
            end
         end
         ST_DRAIN: begin
            if (beat && i_axi_ingress_last) state_d = ST_FINISHED;
         end
         ST_FINISHED: begin
            act_d = 1'b0;
            if (!i_enable) begin
               finished_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // o_finished rises on the edge that accepts the final beat
      if (state_d == ST_FINISHED && state_q != ST_FINISHED) begin
         finished_d = 1'b1;
         act_d      = 1'b0;
      end

      if (beat && i_axi_ingress_keep != 4'hF) error_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= 2'd0;
         hdr_q      <= '0;
         fields_q   <= '0;
         hdr_stb_q  <= 1'b0;
         error_q    <= 1'b0;
         act_q      <= 1'b0;
         finished_q <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         hdr_q      <= hdr_d;
         fields_q   <= fields_d;
         hdr_stb_q  <= hdr_stb_d;
         error_q    <= error_d;
         act_q      <= act_d;
         finished_q <= finished_d;
         count_q    <= count_d;
      end
   end

   assign o_finished     = finished_q;
   assign o_hdr_stb      = hdr_stb_q;
   assign o_error        = error_q;
   assign o_fifo_act     = act_q;
   assign o_command      = fields_q.command;
   assign o_flags        = fields_q.flags;
   assign o_dword_count  = fields_q.dword_count;
   assign o_requester_id = fields_q.requester_id;
   assign o_tag          = fields_q.tag;
   assign o_completer_id = fields_q.completer_id;
   assign o_cpl_status   = fields_q.cpl_status;
   assign o_byte_count   = fields_q.byte_count;
   assign o_address      = fields_q.address;

endmodule

// File: tb/tb_pcie_ingress.sv
// tb/tb_pcie_ingress.sv - directed self-checking bench for pcie_ingress
module tb_pcie_ingress;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_enable;
   logic        o_finished, o_hdr_stb, o_error;
   logic [7:0]  o_command;
   logic [13:0] o_flags;
   logic [10:0] o_dword_count;
   logic [15:0] o_requester_id;
   logic [7:0]  o_tag;
   logic [15:0] o_completer_id;
   logic [2:0]  o_cpl_status;
   logic [11:0] o_byte_count;
   logic [31:0] o_address;
   logic [31:0] i_axi_ingress_data;
   logic [3:0]  i_axi_ingress_keep;
   logic        i_axi_ingress_last, i_axi_ingress_valid, o_axi_ingress_ready;
   logic        i_fifo_rdy, o_fifo_act;
   logic [23:0] i_fifo_size;
   logic [31:0] o_fifo_data;
   logic        o_fifo_stb;

   always #5 clk = ~clk;

   pcie_ingress dut (
      .clk                 (clk),
      .rst                 (rst),
      .i_enable            (i_enable),
      .o_finished          (o_finished),
      .o_hdr_stb           (o_hdr_stb),
      .o_error             (o_error),
      .o_command           (o_command),
      .o_flags             (o_flags),
      .o_dword_count       (o_dword_count),
      .o_requester_id      (o_requester_id),
      .o_tag               (o_tag),
      .o_completer_id      (o_completer_id),
      .o_cpl_status        (o_cpl_status),
      .o_byte_count        (o_byte_count),
      .o_address           (o_address),
      .i_axi_ingress_data  (i_axi_ingress_data),
      .i_axi_ingress_keep  (i_axi_ingress_keep),
      .i_axi_ingress_last  (i_axi_ingress_last),
      .i_axi_ingress_valid (i_axi_ingress_valid),
      .o_axi_ingress_ready (o_axi_ingress_ready),
      .i_fifo_rdy          (i_fifo_rdy),
      .o_fifo_act          (o_fifo_act),
      .i_fifo_size         (i_fifo_size),
      .o_fifo_data         (o_fifo_data),
      .o_fifo_stb          (o_fifo_stb)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // FIFO-side monitor
   int          stb_cnt = 0;
   int          hdr_cnt = 0;
   int          act_cyc = 0;
   logic [31:0] rx_q[$];

   always @(negedge clk) begin
      if (o_fifo_stb === 1'b1) begin
         stb_cnt++;
         rx_q.push_back(o_fifo_data);
      end
      if (o_hdr_stb === 1'b1) hdr_cnt++;
      if (o_fifo_act === 1'b1) act_cyc++;
   end

   logic [31:0] tx_q[$];
   int          bad_keep_idx = -1;
   int          b_stb, b_rx, b_hdr, b_act;

   task automatic send_tx(input int gap_max, input int nsend);
      int  g;
      bit  done;
      logic r;
      for (int i = 0; i < nsend; i++) begin
         g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
         if (g > 0) begin
            i_axi_ingress_valid = 1'b0;
            repeat (g) @(posedge clk);
            #1;
         end
         i_axi_ingress_data  = tx_q[i];
         i_axi_ingress_last  = (i == tx_q.size() - 1);
         i_axi_ingress_keep  = (i == bad_keep_idx) ? 4'h7 : 4'hF;
         i_axi_ingress_valid = 1'b1;
         done = 1'b0;
         for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            r = o_axi_ingress_ready;
            @(posedge clk);
            #1;
            done = r;
         end
         if (!done) begin
            chk("beat_timeout", 0, 1);
            break;
         end
      end
      i_axi_ingress_valid = 1'b0;
      i_axi_ingress_last  = 1'b0;
      i_axi_ingress_data  = 32'h0;
      i_axi_ingress_keep  = 4'hF;
   endtask

   task automatic begin_pkt();
      b_stb = stb_cnt;
      b_rx  = rx_q.size();
      b_hdr = hdr_cnt;
      b_act = act_cyc;
      i_enable = 1'b1;
   endtask

   task automatic end_pkt();
      i_enable = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("finished_clear", o_finished, 0);
   endtask

   task automatic chk_payload(input string tag, input int first, input int n);
      for (int i = 0; i < n; i++)
         if (rx_q.size() > b_rx + i) chk(tag, rx_q[b_rx + i], tx_q[first + i]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      i_enable = 1'b0;
      i_axi_ingress_data = 32'h0;
      i_axi_ingress_keep = 4'hF;
      i_axi_ingress_last = 1'b0;
      i_axi_ingress_valid = 1'b0;
      i_fifo_rdy = 1'b1;
      i_fifo_size = 24'd512;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_ctl", {o_finished, o_hdr_stb, o_error, o_axi_ingress_ready, o_fifo_act, o_fifo_stb}, 0);
      chk("reset_hdr_a", {o_command, o_flags, o_dword_count, o_requester_id, o_tag}, 0);
      chk("reset_hdr_b", {o_completer_id, o_cpl_status, o_byte_count, o_address}, 0);

      // CPLD 3DW, length 4
      tx_q = '{32'h4A00_0004, 32'h0100_0010, 32'h0000_2A04,
               32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
      begin_pkt();
      send_tx(0, tx_q.size());
      chk("cpld4_fin_latency", o_finished, 1);
      chk("cpld4_command", o_command, 8'h4A);
      chk("cpld4_tag", o_tag, 8'h2A);
      chk("cpld4_byte_count", o_byte_count, 12'd16);
      chk("cpld4_address", o_address, 32'h04);
      chk("cpld4_completer", o_completer_id, 16'h0100);
      chk("cpld4_dword_count", o_dword_count, 11'd4);
      chk("cpld4_hdr_stb", hdr_cnt - b_hdr, 1);
      chk("cpld4_strobes", stb_cnt - b_stb, 4);
      chk_payload("cpld4_data", 3, 4);
      chk("cpld4_error", o_error, 0);
      end_pkt();

      // MRD 32-bit, no payload
      tx_q = '{32'h0000_0001, 32'hBEEF_0700, 32'h0000_1000};
      begin_pkt();
      send_tx(0, tx_q.size());
      chk("mrd_fin_latency", o_finished, 1);
      chk("mrd_requester", o_requester_id, 16'hBEEF);
      chk("mrd_tag", o_tag, 8'h07);
      chk("mrd_address", o_address, 32'h0000_1000);
      chk("mrd_completer", o_completer_id, 0);
      chk("mrd_strobes", stb_cnt - b_stb, 0);
      chk("mrd_act_cycles", act_cyc - b_act, 0);
      chk("mrd_error", o_error, 0);
      end_pkt();

      // MWR 64-bit, 4DW header, length 1
      tx_q = '{32'h6000_0001, 32'h1234_0500, 32'h0000_0000, 32'hCAFE_0000, 32'hDEAD_BEEF};
      begin_pkt();
      send_tx(0, tx_q.size());
      chk("mwr64_fin_latency", o_finished, 1);
      chk("mwr64_address", o_address, 32'hCAFE_0000);
      chk("mwr64_requester", o_requester_id, 16'h1234);
      chk("mwr64_tag", o_tag, 8'h05);
      chk("mwr64_strobes", stb_cnt - b_stb, 1);
      chk_payload("mwr64_data", 4, 1);
      chk("mwr64_error", o_error, 0);
      end_pkt();

      // CPLD length 8 truncated after 5 payload beats
      tx_q = '{32'h4A00_0008, 32'h0100_0020, 32'h0000_0100,
               32'h5000_0001, 32'h5000_0002, 32'h5000_0003, 32'h5000_0004, 32'h5000_0005};
      begin_pkt();
      send_tx(0, tx_q.size());
      chk("trunc_fin_latency", o_finished, 1);
      chk("trunc_strobes", stb_cnt - b_stb, 5);
      chk_payload("trunc_data", 3, 5);
      chk("trunc_error", o_error, 1);
      end_pkt();

      // CPLD length 16 into an 8-DWORD FIFO: drained
      i_fifo_size = 24'd8;
      tx_q = '{32'h4A00_0010, 32'h0100_0040, 32'h0000_0200};
      for (int i = 0; i < 16; i++) tx_q.push_back(32'h6000_0000 + i);
      begin_pkt();
      send_tx(0, tx_q.size());
      chk("small_fifo_fin_latency", o_finished, 1);
      chk("small_fifo_strobes", stb_cnt - b_stb, 0);
      chk("small_fifo_error", o_error, 1);
      end_pkt();
      i_fifo_size = 24'd512;

      // CPL, length 0 decodes to 1024, bad keep on DW1
      tx_q = '{32'h0A00_0000, 32'h0200_4004, 32'h0003_0511};
      bad_keep_idx = 1;
      begin_pkt();
      send_tx(0, tx_q.size());
      bad_keep_idx = -1;
      chk("cpl_fin_latency", o_finished, 1);
      chk("cpl_dword_count", o_dword_count, 11'd1024);
      chk("cpl_status", o_cpl_status, 3'd2);
      chk("cpl_byte_count", o_byte_count, 12'd4);
      chk("cpl_requester", o_requester_id, 16'h0003);
      chk("cpl_address", o_address, 32'h11);
      chk("cpl_keep_error", o_error, 1);
      chk("cpl_strobes", stb_cnt - b_stb, 0);
      end_pkt();

      // CPLD length 32 with random valid gaps
      tx_q = '{32'h4A00_0020, 32'h0100_0080, 32'h0000_0900};
      for (int i = 0; i < 32; i++) tx_q.push_back(32'hA000_0000 + i);
      begin_pkt();
      send_tx(3, tx_q.size());
      chk("gaps_fin_latency", o_finished, 1);
      chk("gaps_strobes", stb_cnt - b_stb, 32);
      chk_payload("gaps_data", 3, 32);
      chk("gaps_error", o_error, 0);
      end_pkt();

      // second CPLD 32 interrupted by reset after 10 beats
      tx_q = '{32'h4A00_0020, 32'h0100_0080, 32'h0000_3300};
      for (int i = 0; i < 32; i++) tx_q.push_back(32'hB000_0000 + i);
      begin_pkt();
      send_tx(0, 10);
      chk("rst_mid_strobes", stb_cnt - b_stb, 7);
      rst = 1'b1;
      i_enable = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_mid_ctl", {o_finished, o_hdr_stb, o_error, o_axi_ingress_ready, o_fifo_act, o_fifo_stb}, 0);
      chk("rst_mid_hdr_a", {o_command, o_flags, o_dword_count, o_requester_id, o_tag}, 0);
      chk("rst_mid_hdr_b", {o_completer_id, o_cpl_status, o_byte_count, o_address}, 0);
      chk("rst_mid_fifo_data", o_fifo_data, 0);

      // block recovers after the reset
      tx_q = '{32'h0000_0001, 32'h4321_0900, 32'h0000_2000};
      begin_pkt();
      send_tx(0, tx_q.size());
      chk("recover_fin_latency", o_finished, 1);
      chk("recover_requester", o_requester_id, 16'h4321);
      chk("recover_address", o_address, 32'h0000_2000);
      end_pkt();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
